// File: rtl/memory_stage.sv
// memory_stage: M pipeline stage between execute and writeback.
// Waits for data-SRAM loads, aligns/extends data, drops stale responses.
//
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   ex_en               exception/ertn flush; kills M contents
//   EM_*                execute payload and EM_valid; M_allowin back
//   data_sram_*         load response strobe and data
//   W_allowin, MW_*     writeback handshake and payload
//   M_fwd_*, M_load_pending  forwarding/stall bus to decode
module memory_stage #(
  parameter int CANCEL_W = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_en,
  input  logic        EM_valid,
  output logic        M_allowin,
  input  logic [31:0] EM_pc,
  input  logic [31:0] EM_alu_result,
  input  logic        EM_gr_we,
  input  logic [4:0]  EM_dest,
  input  logic        EM_is_load,
  input  logic [2:0]  EM_mem_op,
  input  logic        EM_req_sent,
  input  logic        EM_ex,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        W_allowin,
  output logic        MW_valid,
  output logic [31:0] MW_pc,
  output logic [31:0] MW_final_result,
  output logic        MW_gr_we,
  output logic [4:0]  MW_dest,
  output logic        MW_ex,
  output logic        M_fwd_we,
  output logic [4:0]  M_fwd_dest,
  output logic [31:0] M_fwd_data,
  output logic        M_load_pending
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic        gr_we;
    logic [4:0]  dest;
    logic        is_load;
    logic [2:0]  mem_op;
    logic        req_sent;
    logic        ex;
  } em_t;

  localparam int SW = CANCEL_W + 2;
  localparam logic [CANCEL_W-1:0] CNT_MAX = '1;

  em_t                 m_q;
  logic                m_valid;
  logic                buf_valid;
  logic [31:0]         buf_data;
  logic [CANCEL_W-1:0] cancel_cnt;

  logic                wait_resp;
  logic                cnt_zero;
  logic                data_ok_eff;
  logic                ready_go;
  logic                leave;
  logic                capture;
  logic [31:0]         raw;
  logic [1:0]          addr;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;
  logic [31:0]         aligned;
  logic [31:0]         final_result;
  logic [SW-1:0]       cnt_sum;
  logic [CANCEL_W-1:0] cnt_next;

  assign wait_resp   = m_valid & m_q.req_sent & ~m_q.ex;
  assign cnt_zero    = (cancel_cnt == '0);
  assign data_ok_eff = data_sram_data_ok & cnt_zero;
  assign ready_go    = ~wait_resp | data_ok_eff | buf_valid;
  assign M_allowin   = ~m_valid | (ready_go & W_allowin);
  assign MW_valid    = m_valid & ready_go;
  assign leave       = MW_valid & W_allowin;
  // Only buffer when writeback stalls; never overwrite a held response.
  assign capture     = wait_resp & data_ok_eff
                     & ~W_allowin & ~buf_valid;

  assign raw    = buf_valid ? buf_data : data_sram_rdata;
  assign addr   = m_q.alu[1:0];
  assign byte_v = raw[{addr, 3'b000} +: 8];
  assign half_v = addr[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    aligned = raw;
    unique case (1'b1)
      (m_q.mem_op == 3'b000): aligned = {{24{byte_v[7]}}, byte_v};
      (m_q.mem_op == 3'b001): aligned = {{16{half_v[15]}}, half_v};
      (m_q.mem_op == 3'b100): aligned = {24'd0, byte_v};
      (m_q.mem_op == 3'b101): aligned = {16'd0, half_v};
      default:                aligned = raw;
    endcase
  end

  assign final_result = (m_q.is_load & ~m_q.ex) ? aligned : m_q.alu;

  // Stale strobes drain the counter; a flush adds the killed waiter
  // and any request execute issued in the same cycle.
  always_comb begin
    cnt_sum = SW'(cancel_cnt);
    if (data_sram_data_ok & ~cnt_zero)
      cnt_sum = cnt_sum - SW'(1);
    if (ex_en) begin
      if (wait_resp & ~data_ok_eff & ~buf_valid)
        cnt_sum = cnt_sum + SW'(1);
      if (EM_valid & EM_req_sent)
        cnt_sum = cnt_sum + SW'(1);
    end
    cnt_next = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX
                                        : cnt_sum[CANCEL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_valid    <= 1'b0;
      m_q        <= '0;
      buf_valid  <= 1'b0;
      buf_data   <= '0;
      cancel_cnt <= '0;
    end else begin
      cancel_cnt <= cnt_next;
      if (ex_en) begin
        m_valid   <= 1'b0;
        buf_valid <= 1'b0;
      end else begin
        if (M_allowin)
          m_valid <= EM_valid;
        if (leave) begin
          buf_valid <= 1'b0;
        end else if (capture) begin
          buf_valid <= 1'b1;
          buf_data  <= data_sram_rdata;
        end
        if (M_allowin & EM_valid)
          m_q <= '{pc:       EM_pc,
                   alu:      EM_alu_result,
                   gr_we:    EM_gr_we,
                   dest:     EM_dest,
                   is_load:  EM_is_load,
                   mem_op:   EM_mem_op,
                   req_sent: EM_req_sent,
                   ex:       EM_ex};
      end
    end
  end

  assign MW_pc           = m_q.pc;
  assign MW_final_result = final_result;
  assign MW_gr_we        = m_q.gr_we & ~m_q.ex;
  assign MW_dest         = m_q.dest;
  assign MW_ex           = m_q.ex;

  assign M_fwd_we       = m_valid & m_q.gr_we & ~m_q.ex;
  assign M_fwd_dest     = m_q.dest;
  assign M_fwd_data     = final_result;
  assign M_load_pending = m_valid & m_q.is_load & ~m_q.ex & ~ready_go;

endmodule
